// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    CHECK,
    HOLD
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Number of payload bytes carried by an operand of data_w bits.
  function automatic int unsigned frame_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles and flags the cycle in which the
// count sits at TIMEOUT_CYC-1 with no strobe clearing it.
module uart_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] count;

  // expire is registered one step early so it is high exactly while the
  // count holds TIMEOUT_CYC-1; the parser lets a coincident strobe win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (!enable || clear) begin
      count  <= '0;
      expire <= 1'b0;
    end else begin
      if (count != LAST) begin
        count <= count + CNT_W'(1);
      end
      expire <= (count == PRE);
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC/CMD/payload/CHK frames from the UART byte stream and offers
// {cmd, operand} on a valid/ready handshake.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        cmd_out,
  output logic [DATA_W-1:0] operand_out,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              err_checksum,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic              busy
);

  localparam int unsigned NB    = frame_bytes(DATA_W);
  localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB - 1);

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       xor_acc;
  logic             timer_en;
  logic             expire;

  assign timer_en = (state == CMD) || (state == PAYLOAD) || (state == CHECK);

  uart_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(timer_en),
    .clear (rx_valid),
    .expire(expire)
  );

  // Frame FSM with registered outputs; error flags default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      xor_acc      <= '0;
      cmd_out      <= '0;
      operand_out  <= '0;
      frame_valid  <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= CMD;
            busy  <= 1'b1;
          end
        end
        CMD: begin
          if (rx_valid) begin
            cmd_out  <= rx_data;
            xor_acc  <= rx_data;
            byte_cnt <= '0;
            state    <= PAYLOAD;
          end else if (expire) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (rx_valid) begin
            operand_out <= DATA_W'({operand_out, rx_data});
            xor_acc     <= xor_acc ^ rx_data;
            byte_cnt    <= byte_cnt + CNT_W'(1);
            if (byte_cnt == LAST_IDX) begin
              state <= CHECK;
            end
          end else if (expire) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        CHECK: begin
          if (rx_valid) begin
            if (rx_data == xor_acc) begin
              frame_valid <= 1'b1;
              state       <= HOLD;
            end else begin
              err_checksum <= 1'b1;
              state        <= IDLE;
              busy         <= 1'b0;
            end
          end else if (expire) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        HOLD: begin
          // Bytes arriving while a frame is held are dropped, never parsed.
          if (rx_valid) begin
            err_overrun <= 1'b1;
          end
          if (frame_ready) begin
            frame_valid <= 1'b0;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          frame_valid <= 1'b0;
          state       <= IDLE;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser (DATA_W=16, TIMEOUT_CYC=50).
`timescale 1ns/1ps
module tb_uart_frame_parser;

  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        cmd_out;
  logic [DATA_W-1:0] operand_out;
  logic              frame_valid;
  logic              frame_ready;
  logic              err_checksum;
  logic              err_timeout;
  logic              err_overrun;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_echk   = 0;
  int n_etmo   = 0;
  int n_eovr   = 0;
  int n_multi  = 0;
  int n_xfer   = 0;

  uart_frame_parser #(
    .DATA_W(DATA_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .cmd_out(cmd_out),
    .operand_out(operand_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .err_checksum(err_checksum),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse and handshake tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_checksum) n_echk++;
      if (err_timeout)  n_etmo++;
      if (err_overrun)  n_eovr++;
      if ((int'(err_checksum) + int'(err_timeout) + int'(err_overrun)) > 1) n_multi++;
      if (frame_valid && frame_ready) n_xfer++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Byte is presented for one cycle; returns 1ns after the edge that sampled it.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] p0,
                            input logic [7:0] p1, input logic [7:0] k);
    send(8'hA5); idle(9);
    send(c);     idle(9);
    send(p0);    idle(9);
    send(p1);    idle(9);
    send(k);
  endtask

  initial begin
    rst         = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    frame_ready = 1'b0;
    idle(3);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd", 64'(cmd_out), 64'd0);
    check("rst_operand", 64'(operand_out), 64'd0);
    check("rst_errs", 64'({err_checksum, err_timeout, err_overrun}), 64'd0);
    rst = 1'b0;
    idle(2);

    // Good frame with immediate acceptance
    frame_ready = 1'b1;
    send(8'hA5);
    check("t1_busy_after_sync", 64'(busy), 64'd1);
    idle(9);
    send(8'h01); idle(9);
    send(8'h12); idle(9);
    send(8'h34); idle(9);
    check("t1_fv_before_chk", 64'(frame_valid), 64'd0);
    send(8'h27);
    check("t1_fv", 64'(frame_valid), 64'd1);
    check("t1_cmd", 64'(cmd_out), 64'h01);
    check("t1_operand", 64'(operand_out), 64'h1234);
    step();
    check("t1_fv_drop", 64'(frame_valid), 64'd0);
    check("t1_busy_idle", 64'(busy), 64'd0);
    idle(9);

    // Bad checksum, then a good frame
    send_frame(8'h01, 8'h12, 8'h34, 8'h00);
    check("t2_err_chk", 64'(err_checksum), 64'd1);
    check("t2_fv", 64'(frame_valid), 64'd0);
    check("t2_busy", 64'(busy), 64'd0);
    step();
    check("t2_err_chk_once", 64'(err_checksum), 64'd0);
    idle(8);
    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    check("t2b_fv", 64'(frame_valid), 64'd1);
    check("t2b_operand", 64'(operand_out), 64'h1234);
    idle(10);

    // Leading garbage before sync
    send(8'h00); idle(9);
    send(8'hFF);
    check("t3_busy_garbage", 64'(busy), 64'd0);
    idle(9);
    send_frame(8'h02, 8'hAB, 8'hCD, 8'h64);
    check("t3_fv", 64'(frame_valid), 64'd1);
    check("t3_cmd", 64'(cmd_out), 64'h02);
    check("t3_operand", 64'(operand_out), 64'hABCD);
    check("t3_no_err", 64'(n_echk), 64'd1);
    idle(10);

    // Strobe landing in the expiry cycle wins over the timeout
    send(8'hA5); idle(9);
    send(8'h01); idle(9);
    send(8'h12); idle(49);
    send(8'h34);
    check("t4a_no_timeout", 64'(err_timeout), 64'd0);
    check("t4a_busy", 64'(busy), 64'd1);
    idle(9);
    send(8'h27);
    check("t4a_fv", 64'(frame_valid), 64'd1);
    check("t4a_operand", 64'(operand_out), 64'h1234);
    idle(10);

    // Timeout fires 50 cycles after the last strobe
    send(8'hA5); idle(9);
    send(8'h01); idle(9);
    send(8'h12);
    idle(49);
    check("t4_tmo_not_yet", 64'(err_timeout), 64'd0);
    check("t4_busy_before", 64'(busy), 64'd1);
    step();
    check("t4_tmo_pulse", 64'(err_timeout), 64'd1);
    check("t4_busy_after", 64'(busy), 64'd0);
    step();
    check("t4_tmo_once", 64'(err_timeout), 64'd0);
    idle(9);
    send_frame(8'h03, 8'h00, 8'h01, 8'h02);
    check("t4b_fv", 64'(frame_valid), 64'd1);
    check("t4b_cmd", 64'(cmd_out), 64'h03);
    check("t4b_operand", 64'(operand_out), 64'h0001);
    idle(10);

    // Backpressure with a dropped byte during HOLD
    frame_ready = 1'b0;
    send_frame(8'h04, 8'h56, 8'h78, 8'h2A);
    check("t5_fv", 64'(frame_valid), 64'd1);
    idle(5);
    send(8'hA5);
    check("t5_overrun", 64'(err_overrun), 64'd1);
    check("t5_fv_held", 64'(frame_valid), 64'd1);
    check("t5_cmd_held", 64'(cmd_out), 64'h04);
    check("t5_operand_held", 64'(operand_out), 64'h5678);
    step();
    check("t5_overrun_once", 64'(err_overrun), 64'd0);
    idle(13);
    check("t5_fv_still", 64'(frame_valid), 64'd1);
    frame_ready = 1'b1;
    step();
    check("t5_fv_xfer", 64'(frame_valid), 64'd0);
    check("t5_busy_xfer", 64'(busy), 64'd0);
    idle(9);
    send(8'h01);
    check("t5_dropped_sync", 64'(busy), 64'd0);
    idle(9);

    // Reset mid-frame
    send(8'hA5); idle(9);
    send(8'h01); idle(9);
    send(8'h12);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_cmd", 64'(cmd_out), 64'd0);
    check("t6_rst_operand", 64'(operand_out), 64'd0);
    idle(2);
    rst = 1'b0;
    idle(2);
    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    check("t6_fv", 64'(frame_valid), 64'd1);
    check("t6_cmd", 64'(cmd_out), 64'h01);
    check("t6_operand", 64'(operand_out), 64'h1234);
    idle(5);

    check("tot_checksum", 64'(n_echk), 64'd1);
    check("tot_timeout", 64'(n_etmo), 64'd1);
    check("tot_overrun", 64'(n_eovr), 64'd1);
    check("tot_err_exclusive", 64'(n_multi), 64'd0);
    check("tot_transfers", 64'(n_xfer), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Downstream consumer of the UART byte receiver.
- Takes the receiver's one-cycle byte strobes, hunts for a sync byte, and collects a command byte plus a fixed-length big-endian operand. It checks an XOR checksum, then presents {cmd, operand} to the RSA core on a valid/ready handshake.
- Detects inter-byte timeouts, checksum mismatches and overruns while the output is stalled.

Parameters:
- DATA_W, 64: operand width in bits; multiple of 8, minimum 8.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 100000: idle clk cycles allowed between bytes inside a frame; minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle byte strobe, driven by the receiver's data_ready.
- cmd_out  out  8  command byte of the accepted frame.
- operand_out  out  DATA_W  operand; the first payload byte lands in the MSB.
- frame_valid  out  1  frame available; held until accepted.
- frame_ready  in  1  consumer accepts the frame.
- err_checksum  out  1  one-cycle pulse: checksum mismatch.
- err_timeout  out  1  one-cycle pulse: inter-byte gap exceeded.
- err_overrun  out  1  one-cycle pulse: byte dropped while holding a frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, byte counter 0, gap counter 0, running XOR 0. Reset mid-frame discards all partial data.
- Frame format: SYNC, CMD, P0..P(N-1) with N=DATA_W/8, then CHK.
  - CHK = CMD ^ P0 ^ ... ^ P(N-1).
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> CMD state.
  - Any other byte is silently discarded; no error.
- CMD: on rx_valid, capture cmd, running XOR = byte, byte counter = 0 -> PAYLOAD.
- PAYLOAD:
  - On each rx_valid: operand shifts left 8 with the byte entering bits [7:0]; XOR accumulates; counter increments.
  - After the N-th byte -> CHECK.
  - A SYNC_BYTE value inside CMD/PAYLOAD/CHECK is treated as data, not a restart.
- CHECK: on rx_valid:
  - byte == running XOR -> HOLD; frame_valid=1 from the next cycle. Latency from the CHK strobe to frame_valid is 1 cycle.
  - Mismatch -> err_checksum pulse in the next cycle, return to IDLE, frame_valid stays 0.
- HOLD:
  - cmd_out and operand_out are stable while frame_valid=1.
  - Transfer occurs on a clock edge with frame_valid & frame_ready. Next cycle: frame_valid=0, state IDLE.
  - An rx_valid in HOLD, including the transfer cycle, drops that byte and pulses err_overrun next cycle. It is not parsed as a sync byte.
- Gap timer (CMD, PAYLOAD, CHECK only):
  - Clears on rx_valid and on entry to CMD; increments on every cycle without rx_valid.
  - When the count reaches TIMEOUT_CYC-1 without a strobe -> err_timeout pulse next cycle, IDLE, partial frame discarded.
  - Timer is held at 0 in IDLE and HOLD.
  - If rx_valid coincides with the expiry cycle, the byte wins and there is no timeout.
- Outputs are registered. Error pulses are mutually exclusive and each lasts exactly one cycle.
- cmd_out and operand_out may change during the parse. Their contents are only meaningful while frame_valid=1.

Decomposition:
- Package uart_frame_pkg: state enum (IDLE, CMD, PAYLOAD, CHECK, HOLD), default SYNC_BYTE constant, and a helper returning the byte count for a given DATA_W.
- One sub-module, uart_gap_timer, parameterised by TIMEOUT_CYC.
  - Inputs: clk, rst, enable, clear.
  - Output: one-cycle expire pulse.
  - Counter width: $clog2(TIMEOUT_CYC).

Test Plan (DATA_W=16, TIMEOUT_CYC=50, strobes spaced 10 cycles):
- Good frame A5 01 12 34 27 -> frame_valid 1 cycle after the 27 strobe; cmd_out=01, operand_out=1234. With frame_ready=1, frame_valid lasts 1 cycle, then busy=0.
- Bad checksum A5 01 12 34 00 -> err_checksum single pulse, frame_valid never asserts, state IDLE. A following good frame is accepted.
- Leading garbage 00 FF A5 02 AB CD 64 -> no errors; cmd_out=02, operand_out=ABCD.
- Timeout: A5 01 12 then 60 idle cycles -> err_timeout pulses once, 50 cycles after the 12 strobe. A subsequent A5 03 00 01 02 yields cmd 03, operand 0001.
- Backpressure: good frame, frame_ready=0 for 20 cycles, byte A5 sent during HOLD -> err_overrun pulse; outputs unchanged. Raise frame_ready -> single transfer, IDLE; the dropped A5 does not start a frame.
- Reset: assert rst after A5 01 12 -> all outputs 0 immediately. After release, frame A5 01 12 34 27 parses correctly.
